// File: rtl/mic_pkg.sv
// Shared microphone-array types: CIC order, accumulator sizing and PCM sample type.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   CIC_ORDER      number of integrator/comb stages
//   acc_w(decim)   accumulator width for an order-CIC_ORDER CIC at ratio decim
//   acc_t          signed accumulator at the default decimation ratio
//   pcm_t          signed PCM sample consumed by the beamformer
package mic_pkg;

   localparam int CIC_ORDER = 3;
   localparam int PCM_W     = 8;
   localparam int DECIM_DEF = 64;

   // Bit growth of an order-N CIC is N*log2(R); one more bit holds the
   // +full-scale value, one more keeps the signed range symmetric.
   function automatic int acc_w(input int decim);
      return CIC_ORDER * $clog2(decim) + 2;
   endfunction

   localparam int ACC_W_DEF = acc_w(DECIM_DEF);

   typedef logic signed [ACC_W_DEF-1:0] acc_t;
   typedef logic signed [PCM_W-1:0]     pcm_t;

endpackage

// File: rtl/cic_channel.sv
// One PDM channel: 3 pipelined integrators, 3 decimated-rate combs, output scaling.
// Latency: integrators on int_en, then one cycle per comb stage; pcm registered with comb3.
// Backpressure: none; the enables come from the shared timing in the top level.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   pdm_bit            captured PDM bit (1 -> +1, 0 -> -1)
//   int_en             integrator update strobe (one per PDM bit)
//   comb1_en..comb3_en comb stage strobes, one cycle apart, once per decimated sample
//   pcm                scaled signed output sample, holds between updates
// Build option: PDM_CIC_SAT_EN selects saturation instead of wrap on the output.
module cic_channel
   import mic_pkg::*;
#(
   parameter int BIT_WIDTH = PCM_W,
   parameter int DECIM     = DECIM_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pdm_bit,
   input  logic                        int_en,
   input  logic                        comb1_en,
   input  logic                        comb2_en,
   input  logic                        comb3_en,
   output logic signed [BIT_WIDTH-1:0] pcm
);

   localparam int ACC_W = acc_w(DECIM);
   // Full scale 2^(3L) lands on 2^(BIT_WIDTH-1) after this shift.
   localparam int SHIFT = ACC_W - 1 - BIT_WIDTH;

   typedef logic signed [ACC_W-1:0] sacc_t;

   sacc_t x;
   sacc_t int1, int2, int3;
   sacc_t comb1, comb2, comb3;
   sacc_t dly1, dly2, dly3;
   sacc_t scaled;
   logic signed [BIT_WIDTH-1:0] pcm_nxt;

   // +1 is 0...01, -1 is 1...11: only the upper bits depend on the input.
   assign x = {{(ACC_W-1){~pdm_bit}}, 1'b1};

   // Last comb is folded into the output register stage.
   assign comb3  = comb2 - dly3;
   assign scaled = comb3 >>> SHIFT;

`ifdef PDM_CIC_SAT_EN
   localparam sacc_t PCM_MAX = sacc_t'((2 ** (BIT_WIDTH - 1)) - 1);
   localparam sacc_t PCM_MIN = sacc_t'(-(2 ** (BIT_WIDTH - 1)));

   always_comb begin
      pcm_nxt = BIT_WIDTH'(scaled);
      if (scaled > PCM_MAX) begin
         pcm_nxt = BIT_WIDTH'(PCM_MAX);
      end else if (scaled < PCM_MIN) begin
         pcm_nxt = BIT_WIDTH'(PCM_MIN);
      end
   end
`else
   // Only +full-scale exceeds the range; it wraps to the most negative code.
   always_comb begin
      pcm_nxt = BIT_WIDTH'(scaled);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         int1  <= '0;
         int2  <= '0;
         int3  <= '0;
         comb1 <= '0;
         comb2 <= '0;
         dly1  <= '0;
         dly2  <= '0;
         dly3  <= '0;
         pcm   <= '0;
      end else begin
         // Each integrator adds the registered value of the stage before it;
         // modular wrap is harmless because the combs undo it exactly.
         if (int_en) begin
            int1 <= int1 + x;
            int2 <= int2 + int1;
            int3 <= int3 + int2;
         end
         if (comb1_en) begin
            comb1 <= int3 - dly1;
            dly1  <= int3;
         end
         if (comb2_en) begin
            comb2 <= comb1 - dly2;
            dly2  <= comb1;
         end
         if (comb3_en) begin
            dly3 <= comb2;
            pcm  <= pcm_nxt;
         end
      end
   end

endmodule

// File: rtl/pdm_cic_decimator.sv
// Multichannel PDM-to-PCM front end: PDM clock generation, bit capture, per-mic 3rd-order CIC.
// Latency: pcm_valid 5 clk cycles after the capture strobe that completes a DECIM-bit frame.
// Backpressure: none; outputs hold until the next one-cycle pcm_valid strobe.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset (priority over everything)
//   en             run enable; low freezes the PDM clock and stops new captures
//   pdm_data_in    one PDM bit per microphone
//   pdm_clk        registered PDM bit clock, period 2*CLK_DIV clk cycles
//   pcm_data_out   per-mic signed PCM sample, indexed by mic
//   pcm_valid      one-cycle strobe marking a new pcm_data_out set
// Build option: PDM_CIC_SAT_EN selects saturation instead of wrap on the output.
module pdm_cic_decimator
   import mic_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int NUM_MICS  = 25,
   parameter int CLK_DIV   = 4,
   parameter int DECIM     = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [NUM_MICS-1:0]         pdm_data_in,
   output logic                        pdm_clk,
   output logic signed [BIT_WIDTH-1:0] pcm_data_out [0:NUM_MICS-1],
   output logic                        pcm_valid
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int DEC_W = $clog2(DECIM);

   logic [DIV_W-1:0]    div_cnt;
   logic                div_wrap;
   logic                pdm_stb;
   logic [NUM_MICS-1:0] pdm_q;
   logic                int_upd;
   logic [DEC_W-1:0]    dec_cnt;
   logic                comb1_go;
   logic                comb2_go;
   logic                comb3_go;

   assign div_wrap = en && (div_cnt == DIV_W'(CLK_DIV - 1));
   // Capture at the end of the high phase, where the mic data is settled.
   assign pdm_stb  = div_wrap && pdm_clk;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt   <= '0;
         pdm_clk   <= 1'b0;
         pdm_q     <= '0;
         int_upd   <= 1'b0;
         dec_cnt   <= '0;
         comb1_go  <= 1'b0;
         comb2_go  <= 1'b0;
         comb3_go  <= 1'b0;
         pcm_valid <= 1'b0;
      end else begin
         if (en) begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
               pdm_clk <= ~pdm_clk;
            end
         end
         if (pdm_stb) begin
            pdm_q <= pdm_data_in;
         end
         // The post-capture pipeline is not gated by en, so an output whose
         // frame already completed is still delivered.
         int_upd <= pdm_stb;
         if (int_upd) begin
            dec_cnt <= dec_cnt + 1'b1;   // DECIM is a power of two: natural wrap
         end
         comb1_go  <= int_upd && (dec_cnt == '1);
         comb2_go  <= comb1_go;
         comb3_go  <= comb2_go;
         pcm_valid <= comb3_go;
      end
   end

   for (genvar g = 0; g < NUM_MICS; g++) begin : g_chan
      cic_channel #(
         .BIT_WIDTH (BIT_WIDTH),
         .DECIM     (DECIM)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .pdm_bit  (pdm_q[g]),
         .int_en   (int_upd),
         .comb1_en (comb1_go),
         .comb2_en (comb2_go),
         .comb3_en (comb3_go),
         .pcm      (pcm_data_out[g])
      );
   end

endmodule
